// File: rtl/mm2s_pkg.sv
// -----------------------------------------------------------------------------
// mm2s_pkg
// Shared types and helpers for the MM2S frame serializer:
//   - state_t    : serializer FSM states
//   - K_*        : 8b10b K-character codes used for idle and framing
//   - beat_t     : one AXI-Stream beat, sized for the widest supported beat
//   - lowest_set : priority encoder returning the lowest set bit of a mask
// -----------------------------------------------------------------------------
package mm2s_pkg;

    // Widest beat the serializer supports; narrower beats are zero-extended.
    localparam int MAX_BYTES = 8;
    localparam int IDX_W     = $clog2(MAX_BYTES);

    localparam logic [7:0] K_IDLE = 8'hBC;  // K28.5 comma / idle
    localparam logic [7:0] K_SOF  = 8'hFB;  // K27.7 start of frame
    localparam logic [7:0] K_EOF  = 8'hFD;  // K29.7 end of frame

    // ST_EOF is reserved for a future registered-EOF variant and never entered.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_EOF  = 2'd2
    } state_t;

    typedef struct packed {
        logic                     tlast;
        logic [MAX_BYTES-1:0]     tkeep;
        logic [8*MAX_BYTES-1:0]   tdata;
    } beat_t;

    // Lowest-index set bit wins; an all-zero mask returns 0. Callers pass the
    // DATA_BYTES-wide keep zero-extended to MAX_BYTES, so the upper bits never
    // win and the result always indexes a real byte lane.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_BYTES-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_BYTES - 1; i >= 0; i--) begin
            if (mask[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mm2s_frame_serializer_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO: the head entry is visible on
// o_rd_data whenever o_empty is low, and i_rd_en consumes it.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_flush           synchronous empty (same effect as reset)
//   i_wr_en/i_wr_data write request; accepted when not full or when popping
//   i_rd_en           pop head (ignored when empty)
//   o_rd_data         head entry
//   o_empty           no entries stored
//   o_level           entries stored, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic w_full;
    logic w_do_rd;
    logic w_do_wr;

    assign w_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    // A push alongside a pop is legal even when full: the slot frees this edge.
    assign w_do_rd = i_rd_en & ~o_empty;
    assign w_do_wr = i_wr_en & (~w_full | w_do_rd);

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // NOTE: storage has no reset; pointers and level alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/mm2s_frame_serializer.sv
// -----------------------------------------------------------------------------
// mm2s_frame_serializer
// Buffers a DATA_BYTES-wide AXI-Stream from the MM2S DMA and serialises it to
// one byte per tx_en slot, framed with SOF/EOF K-chars and padded with IDLE.
// Null (tkeep=0) bytes are skipped; bytes go out in ascending lane order.
// Ports:
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   new_frame                 synchronous flush pulse (frame_cnt survives)
//   s_axis_t*                 AXI-Stream slave (tdata byte 0 sent first)
//   tx_en                     byte slot strobe; serializer advances only when 1
//   txdata, txctrl            registered TX byte and K-char flag
//   tx_underrun               sticky: FIFO ran dry inside a frame
//   fifo_level                beats currently buffered
//   frame_cnt                 frames closed with EOF, wraps at 16 bits
// -----------------------------------------------------------------------------
module mm2s_frame_serializer
    import mm2s_pkg::*;
#(
    parameter int         DATA_BYTES = 4,
    parameter int         FIFO_DEPTH = 512,
    parameter int         PROG_FULL  = 504,
    parameter logic [7:0] IDLE_CHAR  = K_IDLE,
    parameter logic [7:0] SOF_CHAR   = K_SOF,
    parameter logic [7:0] EOF_CHAR   = K_EOF
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          new_frame,
    input  logic [8*DATA_BYTES-1:0]       s_axis_tdata,
    input  logic [DATA_BYTES-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          tx_en,
    output logic [7:0]                    txdata,
    output logic                          txctrl,
    output logic                          tx_underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   frame_cnt
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = 1 + DATA_BYTES + 8 * DATA_BYTES;

    // ---------------- FIFO ----------------
    logic [FW-1:0] w_rd_raw;
    logic          w_empty;
    logic [LW-1:0] w_level;
    logic          w_push;
    logic          w_pop;
    beat_t         w_head;

    assign s_axis_tready = ~sys_rst & ~new_frame & (w_level < LW'(PROG_FULL));
    assign w_push        = s_axis_tvalid & s_axis_tready;
    assign fifo_level    = w_level;

    sync_fifo_fwft #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (sys_clk),
        .i_rst     (sys_rst),
        .i_flush   (new_frame),
        .i_wr_en   (w_push),
        .i_wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_raw),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    // Widen the head beat to the package beat so the selector is width-agnostic.
    always_comb begin
        w_head                         = '0;
        w_head.tlast                   = w_rd_raw[FW-1];
        w_head.tkeep[DATA_BYTES-1:0]   = w_rd_raw[8*DATA_BYTES +: DATA_BYTES];
        w_head.tdata[8*DATA_BYTES-1:0] = w_rd_raw[8*DATA_BYTES-1:0];
    end

    // ---------------- Registers ----------------
    state_t                 r_state;
    logic [MAX_BYTES-1:0]   r_mask;   // bytes of the held beat still to send
    logic [8*MAX_BYTES-1:0] r_data;
    logic                   r_last;
    logic [7:0]             r_txdata;
    logic                   r_txctrl;
    logic                   r_underrun;
    logic [15:0]            r_frame_cnt;

    // ---------------- Byte selector ----------------
    // When the held beat is exhausted the head beat is selected instead, so a
    // continuation beat is popped and its first byte sent in the same slot.
    logic [MAX_BYTES-1:0]   w_sel_mask;
    logic [8*MAX_BYTES-1:0] w_sel_data;
    logic [IDX_W-1:0]       w_sel_idx;
    logic [7:0]             w_sel_byte;
    logic [MAX_BYTES-1:0]   w_sel_rest;

    assign w_sel_mask = (r_mask != '0) ? r_mask : w_head.tkeep;
    assign w_sel_data = (r_mask != '0) ? r_data : w_head.tdata;
    assign w_sel_idx  = lowest_set(w_sel_mask);
    assign w_sel_byte = w_sel_data[{w_sel_idx, 3'b000} +: 8];
    assign w_sel_rest = w_sel_mask & ~(MAX_BYTES'(1) << w_sel_idx);

    // ---------------- Next state ----------------
    state_t w_state_next;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        if (tx_en) begin
            case (r_state)
                ST_IDLE: if (!w_empty) w_state_next = ST_DATA;
                ST_DATA: begin
                    // EOF from the held beat, or from a popped all-null last beat.
                    if (r_mask == '0 &&
                        (r_last || (!w_empty && w_head.tkeep == '0 && w_head.tlast)))
                        w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // ---------------- Outputs / datapath ----------------
    logic [7:0]             w_txdata_next;
    logic                   w_txctrl_next;
    logic [MAX_BYTES-1:0]   w_mask_next;
    logic [8*MAX_BYTES-1:0] w_data_next;
    logic                   w_last_next;
    logic                   w_eof;
    logic                   w_underrun_set;

    always_comb begin
        w_txdata_next  = r_txdata;
        w_txctrl_next  = r_txctrl;
        w_mask_next    = r_mask;
        w_data_next    = r_data;
        w_last_next    = r_last;
        w_pop          = 1'b0;
        w_eof          = 1'b0;
        w_underrun_set = 1'b0;
        if (tx_en) begin
            case (r_state)
                ST_IDLE: begin
                    w_txctrl_next = 1'b1;
                    if (w_empty) begin
                        w_txdata_next = IDLE_CHAR;
                    end else begin
                        w_txdata_next = SOF_CHAR;
                        w_pop         = 1'b1;
                        w_mask_next   = w_head.tkeep;
                        w_data_next   = w_head.tdata;
                        w_last_next   = w_head.tlast;
                    end
                end
                ST_DATA: begin
                    if (r_mask != '0) begin
                        w_txdata_next = w_sel_byte;
                        w_txctrl_next = 1'b0;
                        w_mask_next   = w_sel_rest;
                    end else if (r_last) begin
                        w_txdata_next = EOF_CHAR;
                        w_txctrl_next = 1'b1;
                        w_eof         = 1'b1;
                    end else if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_mask_next = w_sel_rest;
                        w_data_next = w_head.tdata;
                        w_last_next = w_head.tlast;
                        if (w_head.tkeep != '0) begin
                            w_txdata_next = w_sel_byte;
                            w_txctrl_next = 1'b0;
                        end else if (w_head.tlast) begin
                            w_txdata_next = EOF_CHAR;
                            w_txctrl_next = 1'b1;
                            w_eof         = 1'b1;
                        end else begin
                            // All-null continuation beat: slot filled with idle.
                            w_txdata_next = IDLE_CHAR;
                            w_txctrl_next = 1'b1;
                        end
                    end else begin
                        w_txdata_next  = IDLE_CHAR;
                        w_txctrl_next  = 1'b1;
                        w_underrun_set = 1'b1;
                    end
                end
                default: begin
                    w_txdata_next = IDLE_CHAR;
                    w_txctrl_next = 1'b1;
                end
            endcase
        end
    end

    // ---------------- State register ----------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst || new_frame) begin
            r_state    <= ST_IDLE;
            r_mask     <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_txdata   <= IDLE_CHAR;
            r_txctrl   <= 1'b1;
            r_underrun <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_mask   <= w_mask_next;
            r_data   <= w_data_next;
            r_last   <= w_last_next;
            r_txdata <= w_txdata_next;
            r_txctrl <= w_txctrl_next;
            if (w_underrun_set) r_underrun <= 1'b1;
        end
    end

    // The frame counter is the one piece of state a flush leaves alone.
    always_ff @(posedge sys_clk) begin
        if (sys_rst)                r_frame_cnt <= '0;
        else if (!new_frame && w_eof) r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign txdata      = r_txdata;
    assign txctrl      = r_txctrl;
    assign tx_underrun = r_underrun;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_mm2s_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_mm2s_frame_serializer
// Self-checking bench: a queue-based reference model predicts every output
// after every clock edge; directed frames also compare the slot sequence
// against literal byte lists.
// -----------------------------------------------------------------------------
module tb_mm2s_frame_serializer;

    localparam int DB    = 4;
    localparam int DEPTH = 512;
    localparam int PF    = 504;

    logic            sys_clk = 1'b0;
    logic            sys_rst;
    logic            new_frame;
    logic [8*DB-1:0] s_axis_tdata;
    logic [DB-1:0]   s_axis_tkeep;
    logic            s_axis_tlast;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            tx_en;
    logic [7:0]      txdata;
    logic            txctrl;
    logic            tx_underrun;
    logic [9:0]      fifo_level;
    logic [15:0]     frame_cnt;

    always #5 sys_clk = ~sys_clk;

    mm2s_frame_serializer #(
        .DATA_BYTES (DB),
        .FIFO_DEPTH (DEPTH),
        .PROG_FULL  (PF)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .new_frame     (new_frame),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .tx_en         (tx_en),
        .txdata        (txdata),
        .txctrl        (txctrl),
        .tx_underrun   (tx_underrun),
        .fifo_level    (fifo_level),
        .frame_cnt     (frame_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- Reference model ----------------
    typedef struct packed {
        logic            last;
        logic [DB-1:0]   keep;
        logic [8*DB-1:0] data;
    } mbeat_t;

    mbeat_t     m_fifo[$];    // beats accepted, not yet started
    logic [7:0] m_bytes[$];   // kept bytes of the current beat still to send
    bit         m_in_frame;
    bit         m_last;
    logic [7:0] m_txdata;
    bit         m_txctrl;
    bit         m_underrun;
    logic [15:0] m_frame_cnt;

    logic [8:0] cap[$];       // {txctrl, txdata} observed on each active slot
    logic [8:0] exp_seq[$];
    bit         last_acc;

    function automatic void m_clear();
        m_fifo.delete();
        m_bytes.delete();
        m_in_frame = 0;
        m_last     = 0;
        m_txdata   = 8'hBC;
        m_txctrl   = 1;
        m_underrun = 0;
    endfunction

    function automatic void m_load(input mbeat_t b);
        m_bytes.delete();
        for (int i = 0; i < DB; i++)
            if (b.keep[i]) m_bytes.push_back(b.data[8*i +: 8]);
        m_last = b.last;
    endfunction

    function automatic void m_emit(input logic [7:0] d, input bit k);
        m_txdata = d;
        m_txctrl = k;
    endfunction

    function automatic void m_slot();
        if (!m_in_frame) begin
            if (m_fifo.size() == 0) m_emit(8'hBC, 1);
            else begin
                m_emit(8'hFB, 1);
                m_load(m_fifo.pop_front());
                m_in_frame = 1;
            end
        end else if (m_bytes.size() != 0) begin
            m_emit(m_bytes.pop_front(), 0);
        end else if (m_last) begin
            m_emit(8'hFD, 1);
            m_frame_cnt++;
            m_in_frame = 0;
        end else if (m_fifo.size() != 0) begin
            m_load(m_fifo.pop_front());
            if (m_bytes.size() != 0) m_emit(m_bytes.pop_front(), 0);
            else if (m_last) begin
                m_emit(8'hFD, 1);
                m_frame_cnt++;
                m_in_frame = 0;
            end else m_emit(8'hBC, 1);
        end else begin
            m_emit(8'hBC, 1);
            m_underrun = 1;
        end
    endfunction

    // One clock: check tready, advance the model, clock, check all outputs.
    task automatic step();
        bit     exp_ready;
        bit     rec;
        mbeat_t b;
        #1;
        exp_ready = !sys_rst && !new_frame && (m_fifo.size() < PF);
        check("tready", s_axis_tready, exp_ready);
        last_acc = s_axis_tvalid && exp_ready;
        rec      = tx_en && !sys_rst && !new_frame;
        b        = '{s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (sys_rst) begin
            m_clear();
            m_frame_cnt = 0;
        end else if (new_frame) begin
            m_clear();
        end else begin
            if (tx_en) m_slot();
            if (last_acc) m_fifo.push_back(b);
        end
        @(posedge sys_clk);
        #1;
        check("txdata",      txdata,      m_txdata);
        check("txctrl",      txctrl,      m_txctrl);
        check("tx_underrun", tx_underrun, m_underrun);
        check("fifo_level",  fifo_level,  10'(m_fifo.size()));
        check("frame_cnt",   frame_cnt,   m_frame_cnt);
        if (rec) cap.push_back({txctrl, txdata});
    endtask

    task automatic run(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            if (toggle) tx_en = (i % 2 == 0);
            step();
        end
        tx_en = 1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        s_axis_tvalid = 1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        last_acc      = 0;
        for (int i = 0; i < 50 && !last_acc; i++) step();
        if (!last_acc) check("send_timeout", 0, 1);
        s_axis_tvalid = 0;
    endtask

    task automatic compare_cap(input string tag);
        check({tag, "_len"}, cap.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < cap.size(); i++)
            check(tag, cap[i], exp_seq[i]);
    endtask

    mbeat_t offer[$];

    initial begin
        bit     done;
        int     nb;
        mbeat_t ob;

        sys_rst = 1; new_frame = 0; tx_en = 1;
        s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0;
        m_clear();
        m_frame_cnt = 0;

        // Reset held for 3 cycles with tx_en=1.
        repeat (3) step();
        check("rst_txdata", txdata, 8'hBC);
        check("rst_txctrl", txctrl, 1);
        check("rst_frame_cnt", frame_cnt, 0);
        sys_rst = 0;
        step();

        // Single full beat.
        send_beat(32'h44332211, 4'hF, 1);
        cap.delete();
        run(7, 0);
        exp_seq = '{9'h1FB, 9'h011, 9'h022, 9'h033, 9'h044, 9'h1FD, 9'h1BC};
        compare_cap("one_beat");
        check("one_beat_cnt", frame_cnt, 1);

        // Sparse keep: null bytes take no slot.
        send_beat(32'hDDCCBBAA, 4'b0101, 1);
        cap.delete();
        run(5, 0);
        exp_seq = '{9'h1FB, 9'h0AA, 9'h0CC, 9'h1FD, 9'h1BC};
        compare_cap("sparse");

        // Second beat arrives late: idles plus sticky underrun mid-frame.
        send_beat(32'h04030201, 4'hF, 0);
        cap.delete();
        run(9, 0);
        send_beat(32'h08070605, 4'hF, 1);
        run(6, 0);
        exp_seq = '{9'h1FB, 9'h001, 9'h002, 9'h003, 9'h004, 9'h1BC, 9'h1BC,
                    9'h1BC, 9'h1BC, 9'h1BC, 9'h005, 9'h006, 9'h007, 9'h008,
                    9'h1FD, 9'h1BC};
        compare_cap("underrun");
        check("underrun_flag", tx_underrun, 1);

        // tx_en toggling: same slot sequence, each byte held two cycles.
        send_beat(32'h44332211, 4'hF, 1);
        cap.delete();
        run(14, 1);
        exp_seq = '{9'h1FB, 9'h011, 9'h022, 9'h033, 9'h044, 9'h1FD, 9'h1BC};
        compare_cap("toggle");

        // Fill with tx_en=0 until tready drops, then flush.
        new_frame = 1; step(); new_frame = 0;
        tx_en = 0;
        s_axis_tvalid = 1; s_axis_tkeep = 4'hF; s_axis_tlast = 0;
        for (int i = 0; i < 510; i++) begin
            s_axis_tdata = $urandom;
            step();
        end
        #1;
        check("fill_level", fifo_level, 10'd504);
        check("fill_tready", s_axis_tready, 0);
        s_axis_tvalid = 0;
        new_frame = 1; step(); new_frame = 0;
        check("flush_level", fifo_level, 0);
        check("flush_underrun", tx_underrun, 0);
        check("flush_txdata", txdata, 8'hBC);
        check("flush_txctrl", txctrl, 1);
        check("flush_frame_cnt", frame_cnt, 4);
        tx_en = 1;
        step();

        // Random frames, random valid gaps, tx_en pacing and rare flushes.
        for (int f = 0; f < 25; f++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                ob.last = (b == nb - 1);
                ob.keep = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                ob.data = $urandom;
                offer.push_back(ob);
            end
        end
        done = 0;
        for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
            tx_en     = ($urandom_range(0, 3) != 0);
            new_frame = ($urandom_range(0, 499) == 0);
            if (offer.size() != 0 && (s_axis_tvalid || $urandom_range(0, 2) != 0)) begin
                s_axis_tvalid = 1;
                {s_axis_tlast, s_axis_tkeep, s_axis_tdata} = offer[0];
            end else begin
                s_axis_tvalid = 0;
            end
            step();
            if (last_acc) void'(offer.pop_front());
            new_frame = 0;
            done = (offer.size() == 0) && (m_fifo.size() == 0) && !m_in_frame;
        end
        s_axis_tvalid = 0;
        tx_en = 1;
        check("rand_drained", done, 1);
        run(4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
